// File: rtl/simon_key_reverse.sv
// SIMON reverse key schedule: streams round keys k_{T-1} down to k_0 over a valid/ready handshake.
// Optional macro SIMON_KEY_REV_PRELOAD_EN: key_in is the master key and the forward schedule runs first.
module simon_key_reverse #(
    parameter int N = 16,
    parameter int M = 4,
    parameter int T = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N*M-1:0] key_in,
    output logic [N-1:0]   key_o,
    output logic [6:0]     round_o,
    output logic           key_valid,
    input  logic           key_ready,
    output logic           busy,
    output logic           done
);
    // z sequences, MSB = index 0
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic logic [61:0] z_sel(input int n, input int m);
        if (n == 16 && m == 4) return Z0;
        if (n == 24 && m == 3) return Z0;
        if (n == 24 && m == 4) return Z1;
        if (n == 32 && m == 3) return Z2;
        if (n == 32 && m == 4) return Z3;
        if (n == 48 && m == 2) return Z2;
        if (n == 48 && m == 3) return Z3;
        if (n == 64 && m == 2) return Z2;
        if (n == 64 && m == 3) return Z3;
        if (n == 64 && m == 4) return Z4;
        return '0;  // unsupported (N,M) pair
    endfunction

    localparam logic [61:0]  Z = z_sel(N, M);
    localparam logic [N-1:0] C = {{(N-2){1'b1}}, 2'b00};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] STREAM  = 2'd1;
`ifdef SIMON_KEY_REV_PRELOAD_EN
    localparam logic [1:0] PRELOAD = 2'd2;
`endif

    logic [1:0]   state;
    logic [N-1:0] w [M];
    logic [6:0]   lo;
    logic [6:0]   round;
    logic [N-1:0] inv_t;
    logic [N-1:0] prev_key;

    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int unsigned r);
        return (x >> r) | (x << (N - r));
    endfunction

    function automatic logic [N-1:0] zterm(input logic [6:0] i);
        logic [6:0] zi;
        logic [5:0] idx;
        zi  = (i < 7'd62) ? i : i - 7'd62;
        idx = 6'(7'd61 - zi);
        return {{(N-1){1'b0}}, Z[idx]};
    endfunction

    // k_{lo-1} from the window k_lo..k_{lo+M-1}
    always_comb begin
        inv_t = ror(w[M-2], 3);
        if (M == 4) inv_t = inv_t ^ w[0];
        inv_t    = inv_t ^ ror(inv_t, 1);
        prev_key = w[M-1] ^ C ^ zterm(lo - 7'd1) ^ inv_t;
    end

`ifdef SIMON_KEY_REV_PRELOAD_EN
    logic [N-1:0] fwd_t;
    logic [N-1:0] next_key;

    // k_{lo+M} from the window k_lo..k_{lo+M-1}
    always_comb begin
        fwd_t = ror(w[M-1], 3);
        if (M == 4) fwd_t = fwd_t ^ w[1];
        fwd_t    = fwd_t ^ ror(fwd_t, 1);
        next_key = w[0] ^ C ^ zterm(lo) ^ fwd_t;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lo        <= '0;
            round     <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int unsigned j = 0; j < M; j++) w[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned j = 0; j < M; j++) w[j] <= key_in[N*j +: N];
                        busy <= 1'b1;
`ifdef SIMON_KEY_REV_PRELOAD_EN
                        lo    <= '0;
                        state <= PRELOAD;
`else
                        lo        <= 7'(T - M);
                        round     <= 7'(T - 1);
                        key_valid <= 1'b1;
                        state     <= STREAM;
`endif
                    end
                end
`ifdef SIMON_KEY_REV_PRELOAD_EN
                PRELOAD: begin
                    for (int unsigned j = 0; j + 1 < M; j++) w[j] <= w[j+1];
                    w[M-1] <= next_key;
                    lo     <= lo + 7'd1;
                    if (lo == 7'(T - M - 1)) begin
                        round     <= 7'(T - 1);
                        key_valid <= 1'b1;
                        state     <= STREAM;
                    end
                end
`endif
                STREAM: begin
                    if (key_ready) begin
                        if (round == '0) begin
                            key_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            for (int unsigned j = 1; j < M; j++) w[j] <= w[j-1];
                            // once k_0 is inside the window only the buffered keys drain
                            if (lo != '0) begin
                                w[0] <= prev_key;
                                lo   <= lo - 7'd1;
                            end else begin
                                w[0] <= '0;
                            end
                            round <= round - 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign key_o   = w[M-1];
    assign round_o = round;

endmodule

// File: tb/tb_simon_key_reverse.sv
// Directed bench for simon_key_reverse: default 16/4/32 instance and a 64/2/68 instance vs a forward-schedule model.
module tb_simon_key_reverse;
    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         start16 = 1'b0;
    logic         key_ready16 = 1'b0;
    logic [63:0]  key_in16 = '0;
    logic [15:0]  key_o16;
    logic [6:0]   round_o16;
    logic         key_valid16, busy16, done16;

    logic         start64 = 1'b0;
    logic         key_ready64 = 1'b0;
    logic [127:0] key_in64 = '0;
    logic [63:0]  key_o64;
    logic [6:0]   round_o64;
    logic         key_valid64, busy64, done64;

    int checks = 0;
    int failures = 0;

    logic [63:0] m16 [32];
    logic [63:0] m64 [68];
    logic [61:0] z0v = 62'b11111010001001010110000111001101111101000100101011000011100110;
    logic [61:0] z2v = 62'b10101111011100000011010010011000101000010001111110010110110011;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

`ifdef SIMON_KEY_REV_PRELOAD_EN
    localparam int LAT16 = 29;
    localparam int LAT64 = 67;
`else
    localparam int LAT16 = 1;
    localparam int LAT64 = 1;
`endif

    simon_key_reverse u16 (
        .clk(clk), .reset(rst), .start(start16), .key_in(key_in16),
        .key_o(key_o16), .round_o(round_o16), .key_valid(key_valid16),
        .key_ready(key_ready16), .busy(busy16), .done(done16)
    );

    simon_key_reverse #(.N(64), .M(2), .T(68)) u64 (
        .clk(clk), .reset(rst), .start(start64), .key_in(key_in64),
        .key_o(key_o64), .round_o(round_o64), .key_valid(key_valid64),
        .key_ready(key_ready64), .busy(busy64), .done(done64)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror_m(input logic [63:0] x, input int r, input int n);
        logic [63:0] mask;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        return ((x >> r) | (x << (n - r))) & mask;
    endfunction

    // forward SIMON step in its usual ~k ^ 3 form
    function automatic logic [63:0] fwd(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c3, input logic zb, input int n);
        logic [63:0] mask, t;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        t = ror_m(b, 3, n) ^ c3;
        t = t ^ ror_m(t, 1, n);
        return ((~a) & mask) ^ t ^ {63'd0, zb} ^ 64'd3;
    endfunction

    task automatic stream16(input bit bp, input int restart_at, input int abort_at);
        int  lat, exp_r, cyc, acc;
        bit  rdy;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("busy_after_start", {63'd0, busy16}, 64'd1);
        lat = 1;
        while (!key_valid16 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("first_key_latency", lat, LAT16);
        exp_r = 31; acc = 0; cyc = 0;
        while (exp_r >= 0 && cyc < 400) begin
            if (exp_r == abort_at) begin
                key_ready16 = 1'b0;
                rst = 1'b1;
                #1;
                check("reset_mid_valid", {63'd0, key_valid16}, 64'd0);
                check("reset_mid_busy", {63'd0, busy16}, 64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check("key_valid", {63'd0, key_valid16}, 64'd1);
            check("round_o", {57'd0, round_o16}, exp_r);
            check("key_o", {48'd0, key_o16}, m16[exp_r]);
            if (exp_r == 4) check("key_o_r4_hand", {48'd0, key_o16}, 64'h71C3);
            rdy = bp ? (pat[cyc % 4] ^ ($urandom_range(0, 3) == 0)) : 1'b1;
            key_ready16 = rdy;
            start16 = (exp_r == restart_at);
            if (rdy) begin
                exp_r--;
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        start16 = 1'b0;
        key_ready16 = 1'b0;
        check("accept_count", acc, 32);
        check("done_pulse", {63'd0, done16}, 64'd1);
        check("busy_end", {63'd0, busy16}, 64'd0);
        check("valid_end", {63'd0, key_valid16}, 64'd0);
        check("final_key", {48'd0, key_o16}, 64'h0100);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done16}, 64'd0);
    endtask

    task automatic stream64();
        int lat, exp_r, cyc;
        start64 = 1'b1;
        @(negedge clk);
        start64 = 1'b0;
        lat = 1;
        while (!key_valid64 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("first_key_latency_64", lat, LAT64);
        exp_r = 67; cyc = 0;
        key_ready64 = 1'b1;
        while (exp_r >= 0 && cyc < 200) begin
            check("round_o_64", {57'd0, round_o64}, exp_r);
            check("key_o_64", key_o64, m64[exp_r]);
            if (exp_r == 1) check("master_k1_64", key_o64, 64'h0f0e0d0c0b0a0908);
            if (exp_r == 0) check("master_k0_64", key_o64, 64'h0706050403020100);
            exp_r--;
            @(negedge clk);
            cyc++;
        end
        key_ready64 = 1'b0;
        check("accept_count_64", 67 - exp_r, 68);
        check("done_pulse_64", {63'd0, done64}, 64'd1);
        check("busy_end_64", {63'd0, busy64}, 64'd0);
    endtask

    initial begin
        m16[0] = 64'h0100; m16[1] = 64'h0908; m16[2] = 64'h1110; m16[3] = 64'h1918;
        for (int i = 4; i < 32; i++)
            m16[i] = fwd(m16[i-4], m16[i-1], m16[i-3], z0v[61-(i-4)], 16);
        m64[0] = 64'h0706050403020100;
        m64[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 2; i < 68; i++)
            m64[i] = fwd(m64[i-2], m64[i-1], 64'd0, z2v[61-((i-2) % 62)], 64);
`ifdef SIMON_KEY_REV_PRELOAD_EN
        key_in16 = {m16[3][15:0], m16[2][15:0], m16[1][15:0], m16[0][15:0]};
        key_in64 = {m64[1], m64[0]};
`else
        key_in16 = {m16[31][15:0], m16[30][15:0], m16[29][15:0], m16[28][15:0]};
        key_in64 = {m64[67], m64[66]};
`endif

        repeat (2) @(negedge clk);
        check("reset_key_o", {48'd0, key_o16}, 64'd0);
        check("reset_round_o", {57'd0, round_o16}, 64'd0);
        check("reset_valid", {63'd0, key_valid16}, 64'd0);
        check("reset_busy", {63'd0, busy16}, 64'd0);
        check("reset_done", {63'd0, done16}, 64'd0);
        rst = 1'b0;

        key_ready16 = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready_valid", {63'd0, key_valid16}, 64'd0);
        check("idle_ready_busy", {63'd0, busy16}, 64'd0);
        key_ready16 = 1'b0;

        stream16(1'b0, -1, -1);
        stream16(1'b1, -1, -1);
        stream16(1'b0, 20, -1);
        stream16(1'b0, -1, 15);
        stream16(1'b0, -1, -1);
        stream64();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_key_reverse.md
Name: simon_key_reverse

Overview:
- Sequential reverse key schedule for the SIMON decryption path.
- Takes the last M round keys of a schedule and streams round keys in descending order, k_{T-1} down to k_0, over a valid/ready interface.
- Each earlier key is recovered by inverting the forward recurrence: k_i = k_{i+M} ^ c ^ z_j[i mod 62] ^ (I^S^-1)(S^-3 k_{i+M-1} [^ k_{i+1} when M==4]).
  - c = 2^N-4.
  - S^-r = rotate right by r.
- Sits between the key register and the decryption round datapath; one key per accepted handshake.

Parameters:
- N, 16, word size in bits (16/24/32/48/64).
- M, 4, key words (2/3/4).
- T, 32, total rounds (T<=72, T>M).
- z_j: selected from (N,M) exactly as in the forward schedule.
  - Sequences z_0..z_4 are 62-bit, MSB = index 0.
  - Legal (N,M) pairs: (16,4)->z0, (24,3)->z0, (24,4)->z1, (32,3)->z2, (32,4)->z3, (48,2)->z2, (48,3)->z3, (64,2)->z2, (64,3)->z3, (64,4)->z4.
  - Any other (N,M) pair is unsupported.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; loads key_in when idle, ignored when busy.
- key_in  in  N*M  word w at bits [N*(w+1)-1 -: N] = k_{T-M+w} (k_w if SIMON_KEY_REV_PRELOAD_EN is defined).
- key_o  out  N  current round key.
- round_o  out  7  round index of key_o.
- key_valid  out  1  key_o/round_o valid.
- key_ready  in  1  consumer accepts when key_valid && key_ready.
- busy  out  1  high from start accepted until round 0 accepted.
- done  out  1  one-cycle pulse the cycle after round 0 is accepted.

Behaviour:
- Reset values: key_o=0, round_o=0, key_valid=0, busy=0, done=0, window=0, state=IDLE.
- Window register w[0..M-1] holds k_lo..k_lo+M-1; lo is a 7-bit counter.
- Outputs: key_o = w[M-1], round_o = lo+M-1 while round_o >= lo.
- States: IDLE, STREAM (+PRELOAD with macro).
- IDLE, start=1:
  - Load w from key_in; lo=T-M.
  - Go to STREAM.
  - key_valid=1 from the next cycle, so first key latency = 1 cycle after start.
- STREAM, handshake:
  - If lo>0: w[j]<=w[j-1] for j>=1; w[0]<=inverse recurrence computed from the old w with i=lo-1; lo<=lo-1.
  - If lo==0: shift in zero and drain the remaining buffered keys; round_o decrements each accept.
- Accept of round_o==0:
  - key_valid<=0, busy<=0, done<=1 for one cycle.
  - Return to IDLE.
- Stall: key_valid && !key_ready -> key_o and round_o held stable; no state change.
- One key per cycle at key_ready=1 sustained; T accepts total per run.
- z index: i<62 ? i : i-62.
- Inverse combinational path: one rotate/XOR level per key; no multi-cycle arithmetic.
- start while busy: ignored, no effect on the stream.
- reset mid-stream: immediate return to IDLE; key_valid drops asynchronously; the next start is a fresh run.
- key_ready high while key_valid=0: no effect.

Optional Feature:
- Macro: SIMON_KEY_REV_PRELOAD_EN.
- Defined:
  - key_in is the master key k_0..k_{M-1}.
  - start enters PRELOAD, which runs the forward recurrence one key per cycle for T-M cycles, shifting down, until the window holds k_{T-M}..k_{T-1}.
  - It then enters STREAM.
  - key_valid=0 and busy=1 during PRELOAD; first key latency = T-M+1 cycles after start (29 for defaults).
- Undefined:
  - No PRELOAD state and no forward logic.
  - key_in must already hold the last M keys.

Test Plan:
1. PRELOAD_EN, defaults, key_in=64'h1918_1110_0908_0100, key_ready=1 -> key_valid rises 29 cycles after start; 32 keys stream with round_o 31..0; last four keys 1918, 1110, 0908, 0100; done pulses once.
2. No macro, key_in = last 4 keys from the forward model for the same master key -> all 32 outputs match the model in reverse order; latency 1 cycle; final key_o=16'h0100.
3. Backpressure: key_ready toggles 1,0,0,1 pseudo-randomly -> key_o/round_o stable during stalls; no key skipped or duplicated; count = 32.
4. start reasserted at round 20 -> ignored; stream continues 19..0 unchanged.
5. reset asserted at round 15 mid-stream -> key_valid=0, busy=0 immediately; a subsequent start yields a full correct 32-key stream.
6. N=64, M=2, T=68 (z_2) -> i wraps 62 in the z index; rounds 67..0 match the model; k_1,k_0 equal key_in words.
